// File: rtl/seq_det_arbiter.sv
// Round-robin sharing of one Moore-style serial pattern detector between two
// bit-stream requesters; one frame per grant, with a one-cycle result record.
module seq_det_arbiter #(
    parameter int                   PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0]   PATTERN = 4'b0110,
    parameter int                   CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    output logic [1:0]       gnt,
    input  logic [1:0]       bit_valid,
    input  logic [1:0]       bit_data,
    input  logic [1:0]       bit_last,
    output logic             match_pulse,
    output logic             res_valid,
    output logic             res_id,
    output logic [CNT_W-1:0] res_count,
    output logic             res_abort,
    output logic             busy
);

    // state    | meaning
    // S_IDLE   | no owner; arbitrate among requesters
    // S_STREAM | owner granted; bits shift through the detector
    // S_REPORT | one-cycle result strobe, then back to S_IDLE
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_REPORT = 2'd2;

    localparam int                BC_W    = $clog2(PAT_LEN + 1);
    localparam logic [BC_W-1:0]   BC_MAX  = BC_W'(PAT_LEN);
    localparam logic [BC_W-1:0]   BC_MIN1 = BC_W'(PAT_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    logic [1:0]         r_state;
    logic               r_owner;
    logic               r_last_srv;
    logic [PAT_LEN-1:0] r_hist;
    logic [BC_W-1:0]    r_bits;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_match_pulse;
    logic               r_res_id;
    logic [CNT_W-1:0]   r_res_count;
    logic               r_res_abort;

    logic               w_winner;
    logic               w_req_own;
    logic               w_bv;
    logic               w_bd;
    logic               w_bl;
    logic [PAT_LEN-1:0] w_hist_nxt;
    logic [BC_W-1:0]    w_bits_nxt;
    logic               w_match;
    logic [CNT_W-1:0]   w_cnt_nxt;

    // With both asking, the one not served last wins; a single asker always wins.
    always_comb begin
        w_winner = req[1];
        if (req == 2'b11) begin
            w_winner = ~r_last_srv;
        end
    end

    assign w_req_own  = req[r_owner];
    assign w_bv       = bit_valid[r_owner];
    assign w_bd       = bit_data[r_owner];
    assign w_bl       = bit_last[r_owner];

    assign w_hist_nxt = {r_hist[PAT_LEN-2:0], w_bd};
    assign w_bits_nxt = (r_bits == BC_MAX) ? r_bits : r_bits + 1'b1;
    // The incoming bit is the PAT_LEN-th or later once r_bits reaches PAT_LEN-1.
    assign w_match    = (r_bits >= BC_MIN1) && (w_hist_nxt == PATTERN);
    assign w_cnt_nxt  = (w_match && (r_cnt != CNT_MAX)) ? r_cnt + 1'b1 : r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_owner       <= 1'b0;
            r_last_srv    <= 1'b1;
            r_hist        <= '0;
            r_bits        <= '0;
            r_cnt         <= '0;
            r_match_pulse <= 1'b0;
            r_res_id      <= 1'b0;
            r_res_count   <= '0;
            r_res_abort   <= 1'b0;
        end else begin
            r_match_pulse <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (|req) begin
                        r_state    <= S_STREAM;
                        r_owner    <= w_winner;
                        r_last_srv <= w_winner;
                        r_hist     <= '0;
                        r_bits     <= '0;
                        r_cnt      <= '0;
                    end
                end
                S_STREAM: begin
                    if (!w_req_own) begin
                        r_state     <= S_REPORT;
                        r_res_id    <= r_owner;
                        r_res_count <= r_cnt;
                        r_res_abort <= 1'b1;
                    end else if (w_bv) begin
                        r_hist        <= w_hist_nxt;
                        r_bits        <= w_bits_nxt;
                        r_cnt         <= w_cnt_nxt;
                        r_match_pulse <= w_match;
                        if (w_bl) begin
                            r_state     <= S_REPORT;
                            r_res_id    <= r_owner;
                            r_res_count <= w_cnt_nxt;
                            r_res_abort <= 1'b0;
                        end
                    end
                end
                S_REPORT: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt         = (r_state == S_STREAM) ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
    assign match_pulse = r_match_pulse;
    assign res_valid   = (r_state == S_REPORT);
    assign res_id      = r_res_id;
    assign res_count   = r_res_count;
    assign res_abort   = r_res_abort;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_seq_det_arbiter.sv
// Bench for seq_det_arbiter: directed frames with literal expectations, then
// random traffic checked every cycle against a frame-level reference model.
module tb_seq_det_arbiter;

    localparam int PAT_LEN = 4;
    localparam int PAT_VAL = 6;   // 4'b0110

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req = 2'b00;
    logic [1:0] bit_valid = 2'b00;
    logic [1:0] bit_data = 2'b00;
    logic [1:0] bit_last = 2'b00;

    logic [1:0] gnt_a, gnt_b;
    logic       mp_a, mp_b, rv_a, rv_b, id_a, id_b, ab_a, ab_b, busy_a, busy_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;

    seq_det_arbiter u_dut_a (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt_a),
        .bit_valid(bit_valid), .bit_data(bit_data), .bit_last(bit_last),
        .match_pulse(mp_a), .res_valid(rv_a), .res_id(id_a),
        .res_count(cnt_a), .res_abort(ab_a), .busy(busy_a)
    );

    seq_det_arbiter #(.CNT_W(2)) u_dut_b (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt_b),
        .bit_valid(bit_valid), .bit_data(bit_data), .bit_last(bit_last),
        .match_pulse(mp_b), .res_valid(rv_b), .res_id(id_b),
        .res_count(cnt_b), .res_abort(ab_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: tracks the phase of the frame and keeps every accepted
    // bit of the current frame; a match is "the last PAT_LEN bits spell PATTERN".
    int         m_phase = 0;   // 0 idle, 1 streaming, 2 reporting
    int         m_owner = 0;
    int         m_last_served = 1;
    bit         m_q[$];
    int         m_cnt = 0;
    logic [1:0] e_gnt = 2'b00;
    logic       e_mp = 1'b0, e_rv = 1'b0, e_id = 1'b0, e_ab = 1'b0, e_busy = 1'b0;
    int         e_cnt = 0;

    function automatic bit tail_matches();
        int v;
        int n;
        n = m_q.size();
        if (n < PAT_LEN) return 1'b0;
        v = 0;
        for (int i = n - PAT_LEN; i < n; i++) v = v * 2 + int'(m_q[i]);
        return v == PAT_VAL;
    endfunction

    task automatic model_step();
        if (rst) begin
            m_phase = 0; m_owner = 0; m_last_served = 1; m_q.delete(); m_cnt = 0;
            e_mp = 0; e_id = 0; e_ab = 0; e_cnt = 0;
        end else begin
            e_mp = 0;
            case (m_phase)
                0: if (req != 2'b00) begin
                    if (req == 2'b11) m_owner = 1 - m_last_served;
                    else m_owner = req[1] ? 1 : 0;
                    m_last_served = m_owner;
                    m_q.delete();
                    m_cnt = 0;
                    m_phase = 1;
                end
                1: if (!req[m_owner]) begin
                    m_phase = 2; e_id = m_owner[0]; e_ab = 1; e_cnt = m_cnt;
                end else if (bit_valid[m_owner]) begin
                    m_q.push_back(bit_data[m_owner]);
                    if (tail_matches()) begin
                        m_cnt++;
                        e_mp = 1;
                    end
                    if (bit_last[m_owner]) begin
                        m_phase = 2; e_id = m_owner[0]; e_ab = 0; e_cnt = m_cnt;
                    end
                end
                default: m_phase = 0;
            endcase
        end
        e_gnt  = (m_phase == 1) ? ((m_owner == 1) ? 2'b10 : 2'b01) : 2'b00;
        e_rv   = (m_phase == 2);
        e_busy = (m_phase != 0);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    bit         chk_en = 1'b0;
    bit         res_seen = 1'b0;
    int         res_n = 0;
    int         mp_seen = 0;
    logic       cap_id, cap_ab;
    logic [7:0] cap_cnt_a;
    logic [1:0] cap_cnt_b;

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("gnt_a", gnt_a, e_gnt);
            chk("gnt_b", gnt_b, e_gnt);
            chk("match_pulse_a", mp_a, e_mp);
            chk("match_pulse_b", mp_b, e_mp);
            chk("res_valid_a", rv_a, e_rv);
            chk("res_valid_b", rv_b, e_rv);
            chk("busy_a", busy_a, e_busy);
            if (e_rv) begin
                chk("res_id_a", id_a, e_id);
                chk("res_id_b", id_b, e_id);
                chk("res_abort_a", ab_a, e_ab);
                chk("res_count_a", cnt_a, (e_cnt > 255) ? 255 : e_cnt);
                chk("res_count_b", cnt_b, (e_cnt > 3) ? 3 : e_cnt);
            end
            if (mp_a === 1'b1) mp_seen++;
            if (rv_a === 1'b1) begin
                cap_id = id_a; cap_ab = ab_a; cap_cnt_a = cnt_a; cap_cnt_b = cnt_b;
                res_n++;
                res_seen = 1'b1;
            end
        end
    end

    task automatic wait_gnt(input logic [1:0] exp);
        int k;
        k = 0;
        while (gnt_a !== exp && k < 30) begin
            @(negedge clk);
            k++;
        end
        chk("wait_gnt", gnt_a, exp);
    endtask

    task automatic wait_res();
        int k;
        k = 0;
        while (!res_seen && k < 12) begin
            @(negedge clk);
            k++;
        end
        chk("res_seen", res_seen, 1);
    endtask

    // Called at a falling edge while granted; one bit per cycle, MSB first.
    task automatic stream(input int who, input logic [15:0] bits, input int n, input bit last);
        res_seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            bit_valid[who] = 1'b1;
            bit_data[who]  = bits[n-1-i];
            bit_last[who]  = last && (i == n - 1);
            @(negedge clk);
        end
        bit_valid[who] = 1'b0;
        bit_data[who]  = 1'b0;
        bit_last[who]  = 1'b0;
    endtask

    task automatic frame(input int who, input logic [15:0] bits, input int n);
        req[who] = 1'b1;
        wait_gnt((who == 1) ? 2'b10 : 2'b01);
        mp_seen = 0;
        stream(who, bits, n, 1'b1);
        req[who] = 1'b0;
        wait_res();
    endtask

    initial begin
        int rn;
        rst = 1'b1;
        @(posedge clk);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_gnt", gnt_a, 2'b00);
        chk("rst_busy", busy_a, 0);
        chk("rst_res_count", cnt_a, 0);
        rst = 1'b0;
        @(negedge clk);

        // Both requesting from reset: 0 first, then 1, then 0 again.
        req = 2'b11;
        bit_valid[1] = 1'b1; bit_data[1] = 1'b1; bit_last[1] = 1'b1;
        wait_gnt(2'b01);
        stream(0, 16'b0110, 4, 1'b1);
        bit_valid[1] = 1'b0; bit_data[1] = 1'b0; bit_last[1] = 1'b0;
        req[0] = 1'b0;
        wait_res();
        chk("rr0_count", cap_cnt_a, 1);
        chk("rr0_id", cap_id, 0);
        wait_gnt(2'b10);
        req[0] = 1'b1;
        stream(1, 16'b0110110, 7, 1'b1);
        req[1] = 1'b0;
        wait_res();
        chk("rr1_count", cap_cnt_a, 2);
        chk("rr1_id", cap_id, 1);
        wait_gnt(2'b01);
        stream(0, 16'b01, 2, 1'b1);
        req[0] = 1'b0;
        wait_res();
        chk("rr2_count", cap_cnt_a, 0);

        // Requester 0 alone: 0110110 gives two overlapping matches.
        frame(0, 16'b0110110, 7);
        chk("t1_pulses", mp_seen, 2);
        chk("t1_count", cap_cnt_a, 2);
        chk("t1_id", cap_id, 0);
        chk("t1_abort", cap_ab, 0);

        // No overlap across frames.
        frame(0, 16'b011, 3);
        chk("xa_count", cap_cnt_a, 0);
        frame(0, 16'b0, 1);
        chk("xb_count", cap_cnt_a, 0);
        chk("xb_pulses", mp_seen, 0);

        // Abort by request drop; the valid in the drop cycle is ignored.
        req[1] = 1'b1;
        wait_gnt(2'b10);
        stream(1, 16'b01101, 5, 1'b0);
        req[1] = 1'b0;
        bit_valid[1] = 1'b1; bit_data[1] = 1'b0;
        wait_res();
        bit_valid[1] = 1'b0;
        chk("ab_count", cap_cnt_a, 1);
        chk("ab_id", cap_id, 1);
        chk("ab_abort", cap_ab, 1);

        // Counter saturation on the 2-bit instance.
        frame(0, 16'b0110110110110, 13);
        chk("sat_pulses", mp_seen, 4);
        chk("sat_count_b", cap_cnt_b, 3);
        chk("sat_count_a", cap_cnt_a, 4);

        // Reset mid-frame discards it and clears the history.
        req[0] = 1'b1;
        wait_gnt(2'b01);
        stream(0, 16'b011, 3, 1'b0);
        rn = res_n;
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_gnt", gnt_a, 2'b00);
        chk("mrst_busy", busy_a, 0);
        chk("mrst_pulse", mp_a, 0);
        chk("mrst_res_valid", rv_a, 0);
        chk("mrst_res_count", cnt_a, 0);
        chk("mrst_res_abort", ab_a, 0);
        rst = 1'b0;
        req[0] = 1'b0;
        @(negedge clk);
        chk("mrst_no_result", res_n, rn);
        frame(0, 16'b0110, 4);
        chk("mrst_count", cap_cnt_a, 1);

        // Random traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 19) == 0) req[0] = ~req[0];
            if ($urandom_range(0, 19) == 0) req[1] = ~req[1];
            bit_valid = 2'($urandom_range(0, 3));
            bit_data  = 2'($urandom_range(0, 3));
            bit_last[0] = ($urandom_range(0, 11) == 0);
            bit_last[1] = ($urandom_range(0, 11) == 0);
            rst = ($urandom_range(0, 599) == 0);
            @(negedge clk);
        end
        rst = 1'b0; req = 2'b00; bit_valid = 2'b00; bit_last = 2'b00;
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
